// File: rtl/bid_round_ctrl.sv
// Sealed-bid round controller: keyed lock, per-bidder balances, round timer and winner debit.
// Optional feature: define BID_RETRACT_EN to let the current leader withdraw its bid mid-round.
module bid_round_ctrl #(
  parameter int N_BIDDERS = 3,
  parameter int AMT_W     = 16,
  parameter int BAL_W     = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_BIDDERS-1:0]         bid,
  input  logic [N_BIDDERS-1:0]         retract,
  input  logic [N_BIDDERS*AMT_W-1:0]   bid_amt,
  input  logic [3:0]                   c_op,
  input  logic [31:0]                  c_data,
  input  logic                         c_start,
  output logic [N_BIDDERS-1:0]         ack,
  output logic [2*N_BIDDERS-1:0]       bidder_err,
  output logic [N_BIDDERS*BAL_W-1:0]   balance,
  output logic [N_BIDDERS-1:0]         win,
  output logic [AMT_W-1:0]             max_bid,
  output logic                         ready,
  output logic [2:0]                   err,
  output logic                         round_over
);
  localparam int         IDX_W = $clog2(N_BIDDERS);
  localparam logic [3:0] N_LIM = 4'(N_BIDDERS);

  localparam logic [3:0] OP_UNLOCK = 4'd1;
  localparam logic [3:0] OP_LOCK   = 4'd2;
  localparam logic [3:0] OP_LOAD   = 4'd3;
  localparam logic [3:0] OP_TIMER  = 4'd4;

  localparam logic [2:0] ERR_NONE = 3'b000;
  localparam logic [2:0] ERR_KEY  = 3'b001;
  localparam logic [2:0] ERR_ILL  = 3'b010;
  localparam logic [2:0] ERR_OPC  = 3'b011;

  localparam logic [1:0] BE_BAL   = 2'b01;
  localparam logic [1:0] BE_LOW   = 2'b10;
  localparam logic [1:0] BE_STATE = 2'b11;

  typedef enum logic [1:0] {UNLOCKED, LOCKED, ROUND_ACTIVE, ROUND_OVER} state_t;

  state_t             state;
  logic [31:0]        key;
  logic [15:0]        reload;
  logic [15:0]        timer;
  logic [BAL_W-1:0]   bal [N_BIDDERS];
  logic [AMT_W-1:0]   amt [N_BIDDERS];
  logic [IDX_W-1:0]   lead;
  logic               lead_vld;

  logic [N_BIDDERS-1:0]   bid_eff;
  logic [N_BIDDERS-1:0]   valid;
  logic [N_BIDDERS-1:0]   ack_nxt;
  logic [2*N_BIDDERS-1:0] berr_nxt;
  logic [AMT_W-1:0]       eff_max;
  logic                   eff_lead_vld;
  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic [AMT_W-1:0]       win_amt;
  logic [IDX_W-1:0]       nxt_lead;
  logic                   nxt_lead_vld;
  logic [AMT_W-1:0]       nxt_max;

  logic unused_retract;
  assign unused_retract = ^retract;

  for (genvar g = 0; g < N_BIDDERS; g++) begin : g_unpack
    assign amt[g]                       = bid_amt[g*AMT_W +: AMT_W];
    assign balance[g*BAL_W +: BAL_W]    = bal[g];
  end

  // Bid arbitration: retracts first, then every bid is classified and the highest valid one wins.
  always_comb begin
    ack_nxt      = '0;
    berr_nxt     = '0;
    bid_eff      = bid;
    valid        = '0;
    eff_max      = max_bid;
    eff_lead_vld = lead_vld;
    win_found    = 1'b0;
    win_idx      = '0;
    win_amt      = '0;
`ifdef BID_RETRACT_EN
    if (state == ROUND_ACTIVE) begin
      bid_eff = bid & ~retract;
      for (int i = 0; i < N_BIDDERS; i++) begin
        if (retract[i]) begin
          if (lead_vld && lead == IDX_W'(i)) begin
            eff_lead_vld = 1'b0;
            eff_max      = '0;
            ack_nxt[i]   = 1'b1;
          end else begin
            berr_nxt[2*i +: 2] = BE_LOW;
          end
        end
      end
    end
`endif
    for (int i = 0; i < N_BIDDERS; i++) begin
      if (bid_eff[i]) begin
        if (state != ROUND_ACTIVE)            berr_nxt[2*i +: 2] = BE_STATE;
        else if (BAL_W'(amt[i]) > bal[i])     berr_nxt[2*i +: 2] = BE_BAL;
        else if (amt[i] <= eff_max)           berr_nxt[2*i +: 2] = BE_LOW;
        else begin
          valid[i] = 1'b1;
          // strictly-greater replacement keeps the lowest index on ties
          if (!win_found || amt[i] > win_amt) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(i);
            win_amt   = amt[i];
          end
        end
      end
    end
    for (int i = 0; i < N_BIDDERS; i++) begin
      if (valid[i]) begin
        if (win_idx == IDX_W'(i)) ack_nxt[i] = 1'b1;
        else                      berr_nxt[2*i +: 2] = BE_LOW;
      end
    end
    nxt_lead_vld = win_found ? 1'b1    : eff_lead_vld;
    nxt_lead     = win_found ? win_idx : lead;
    nxt_max      = win_found ? win_amt : eff_max;
  end

  // Controller FSM; a c_start in LOCKED takes priority over any concurrent legal opcode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= UNLOCKED;
      key        <= '0;
      reload     <= 16'd100;
      timer      <= '0;
      for (int i = 0; i < N_BIDDERS; i++) bal[i] <= '0;
      max_bid    <= '0;
      lead       <= '0;
      lead_vld   <= 1'b0;
      ack        <= '0;
      bidder_err <= '0;
      win        <= '0;
      err        <= ERR_NONE;
      round_over <= 1'b0;
      ready      <= 1'b1;
    end else begin
      ack        <= ack_nxt;
      bidder_err <= berr_nxt;
      win        <= '0;
      round_over <= 1'b0;
      err        <= (c_op > OP_TIMER) ? ERR_OPC : ERR_NONE;
      case (state)
        UNLOCKED: begin
          case (c_op)
            OP_UNLOCK: err <= ERR_ILL;
            OP_LOCK: begin
              key   <= c_data;
              state <= LOCKED;
            end
            OP_LOAD: begin
              if (c_data[31:28] >= N_LIM) err <= ERR_ILL;
              for (int i = 0; i < N_BIDDERS; i++)
                if (c_data[31:28] == 4'(i)) bal[i] <= BAL_W'(c_data[27:0]);
            end
            OP_TIMER: reload <= c_data[15:0];
            default: ;
          endcase
        end
        LOCKED: begin
          if (c_start) begin
            state    <= ROUND_ACTIVE;
            ready    <= 1'b0;
            timer    <= (reload == 16'd0) ? 16'd1 : reload;
            max_bid  <= '0;
            lead_vld <= 1'b0;
          end else if (c_op == OP_UNLOCK) begin
            if (c_data == key) state <= UNLOCKED;
            else               err   <= ERR_KEY;
          end else if (c_op inside {OP_LOCK, OP_LOAD, OP_TIMER}) begin
            err <= ERR_ILL;
          end
        end
        ROUND_ACTIVE: begin
          if (c_op inside {[OP_UNLOCK:OP_TIMER]}) err <= ERR_ILL;
          lead     <= nxt_lead;
          lead_vld <= nxt_lead_vld;
          max_bid  <= nxt_max;
          timer    <= timer - 16'd1;
          // last active cycle: bids of this cycle are already folded into nxt_*
          if (timer <= 16'd1) begin
            state      <= ROUND_OVER;
            round_over <= 1'b1;
            for (int i = 0; i < N_BIDDERS; i++) begin
              if (nxt_lead_vld && nxt_lead == IDX_W'(i)) begin
                win[i] <= 1'b1;
                bal[i] <= bal[i] - BAL_W'(nxt_max);
              end
            end
          end
        end
        ROUND_OVER: begin
          if (c_op inside {[OP_UNLOCK:OP_TIMER]}) err <= ERR_ILL;
          state <= LOCKED;
          ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bid_round_ctrl.sv
// Self-checking bench for bid_round_ctrl: directed scenarios plus randomized traffic vs a behavioural model.
module tb_bid_round_ctrl;
  localparam int N  = 3;
  localparam int AW = 16;
  localparam int BW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      bid, retract, ack, win;
  logic [N*AW-1:0]   bid_amt;
  logic [3:0]        c_op;
  logic [31:0]       c_data;
  logic              c_start;
  logic [2*N-1:0]    bidder_err;
  logic [N*BW-1:0]   balance;
  logic [AW-1:0]     max_bid;
  logic              ready;
  logic [2:0]        err;
  logic              round_over;

  int errors = 0;
  int checks = 0;

  bid_round_ctrl #(.N_BIDDERS(N), .AMT_W(AW), .BAL_W(BW)) dut (
    .clk(clk), .reset(reset), .bid(bid), .retract(retract), .bid_amt(bid_amt),
    .c_op(c_op), .c_data(c_data), .c_start(c_start), .ack(ack), .bidder_err(bidder_err),
    .balance(balance), .win(win), .max_bid(max_bid), .ready(ready), .err(err),
    .round_over(round_over)
  );

  always #5 clk = ~clk;

  // Behavioural model: auction rules applied to whole-round quantities.
  typedef enum int {M_UNL, M_LCK, M_ACT, M_OVR} mode_t;
  mode_t        m_mode;
  logic [31:0]  m_key;
  int           m_reload, m_left, m_lead, m_max;
  longint       m_bal [N];
  logic [N-1:0] e_ack, e_win;
  logic [2*N-1:0] e_berr;
  logic [2:0]   e_err;
  logic         e_ro;

  function automatic void model_reset();
    m_mode = M_UNL; m_key = '0; m_reload = 100; m_left = 0; m_lead = -1; m_max = 0;
    for (int i = 0; i < N; i++) m_bal[i] = 0;
    e_ack = '0; e_win = '0; e_berr = '0; e_err = '0; e_ro = 1'b0;
  endfunction

  function automatic void model_step(input logic [N-1:0] b, input logic [N-1:0] r,
                                     input logic [N*AW-1:0] amts, input logic [3:0] op,
                                     input logic [31:0] data, input logic st);
    int a [N];
    logic [N-1:0] bb, cand;
    int top, best, idx;
    e_ack = '0; e_win = '0; e_berr = '0; e_err = '0; e_ro = 1'b0;
    for (int i = 0; i < N; i++) a[i] = int'(amts[i*AW +: AW]);
    bb = b;
`ifdef BID_RETRACT_EN
    if (m_mode == M_ACT)
      for (int i = 0; i < N; i++)
        if (r[i]) begin
          bb[i] = 1'b0;
          if (m_lead == i) begin m_lead = -1; m_max = 0; e_ack[i] = 1'b1; end
          else e_berr[2*i +: 2] = 2'b10;
        end
`else
    if (r != r) e_err = 3'b111;
`endif
    cand = '0;
    for (int i = 0; i < N; i++)
      if (bb[i]) begin
        if (m_mode != M_ACT)      e_berr[2*i +: 2] = 2'b11;
        else if (a[i] > m_bal[i]) e_berr[2*i +: 2] = 2'b01;
        else if (a[i] <= m_max)   e_berr[2*i +: 2] = 2'b10;
        else cand[i] = 1'b1;
      end
    top = -1;
    for (int i = 0; i < N; i++) if (cand[i] && a[i] > top) top = a[i];
    best = -1;
    for (int i = 0; i < N; i++) if (cand[i] && a[i] == top && best < 0) best = i;
    for (int i = 0; i < N; i++)
      if (cand[i] && i != best) e_berr[2*i +: 2] = 2'b10;
    if (best >= 0) begin m_lead = best; m_max = top; e_ack[best] = 1'b1; end

    if (op >= 4'd5) e_err = 3'b011;
    case (m_mode)
      M_UNL: begin
        if (op == 4'd1) e_err = 3'b010;
        else if (op == 4'd2) begin m_key = data; m_mode = M_LCK; end
        else if (op == 4'd3) begin
          idx = int'(data[31:28]);
          if (idx >= N) e_err = 3'b010; else m_bal[idx] = longint'(data[27:0]);
        end else if (op == 4'd4) m_reload = int'(data[15:0]);
      end
      M_LCK: begin
        if (st) begin
          m_mode = M_ACT; m_left = (m_reload == 0) ? 1 : m_reload; m_max = 0; m_lead = -1;
        end else if (op == 4'd1) begin
          if (data == m_key) m_mode = M_UNL; else e_err = 3'b001;
        end else if (op inside {[2:4]}) e_err = 3'b010;
      end
      M_ACT: begin
        if (op inside {[1:4]}) e_err = 3'b010;
        m_left--;
        if (m_left == 0) begin
          m_mode = M_OVR; e_ro = 1'b1;
          if (m_lead >= 0) begin e_win[m_lead] = 1'b1; m_bal[m_lead] -= m_max; end
        end
      end
      M_OVR: begin
        if (op inside {[1:4]}) e_err = 3'b010;
        m_mode = M_LCK;
      end
    endcase
  endfunction

  function automatic logic [N*BW-1:0] exp_bal();
    logic [N*BW-1:0] v;
    for (int i = 0; i < N; i++) v[i*BW +: BW] = BW'(m_bal[i]);
    return v;
  endfunction

  function automatic logic [N*AW-1:0] amts3(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                            input logic [AW-1:0] a2);
    return {a2, a1, a0};
  endfunction

  task automatic step(input logic [N-1:0] b, input logic [N-1:0] r, input logic [N*AW-1:0] amts,
                      input logic [3:0] op, input logic [31:0] data, input logic st);
    bid = b; retract = r; bid_amt = amts; c_op = op; c_data = data; c_start = st;
    model_step(b, r, amts, op, data, st);
    @(posedge clk); #1;
    bid = '0; retract = '0; c_op = '0; c_start = 1'b0;
  endtask

  task automatic idle();
    step('0, '0, '0, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic op(input logic [3:0] o, input logic [31:0] d);
    step('0, '0, '0, o, d, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; bid = '0; retract = '0; bid_amt = '0; c_op = '0; c_data = '0; c_start = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++; if ({ack, bidder_err, win, round_over, err} !== '0) begin errors++;
      $display("FAIL reset_outputs: got ack=%b berr=%b win=%b ro=%b err=%b want all 0", ack, bidder_err, win, round_over, err); end
    checks++; if (max_bid !== '0 || balance !== '0) begin errors++;
      $display("FAIL reset_data: got max=%h bal=%h want 0", max_bid, balance); end
  endtask

  task automatic test_setup();
    op(4'd3, 32'h0000_1000);
    checks++; if (err !== 3'b000 || balance[31:0] !== 32'h0000_1000) begin errors++;
      $display("FAIL load_bal: got err=%b bal0=%h want 000 00001000", err, balance[31:0]); end
    op(4'd4, 32'd5);
    op(4'd2, 32'h0000_A5A5);
    checks++; if (ready !== 1'b1 || err !== 3'b000) begin errors++;
      $display("FAIL lock: got ready=%b err=%b want 1 000", ready, err); end
  endtask

  task automatic test_single_round();
    step('0, '0, '0, 4'd0, 32'd0, 1'b1);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL start_ready: got %b want 0", ready); end
    step(3'b001, '0, amts3(16'h0100, 16'h0, 16'h0), 4'd0, 32'd0, 1'b0);
    checks++; if (ack !== 3'b001 || max_bid !== 16'h0100 || bidder_err !== '0) begin errors++;
      $display("FAIL first_bid: got ack=%b max=%h berr=%b want 001 0100 0", ack, max_bid, bidder_err); end
    for (int k = 0; k < 3; k++) begin
      idle();
      checks++; if (round_over !== 1'b0) begin errors++; $display("FAIL early_over: cycle %0d got %b want 0", k, round_over); end
    end
    idle();
    checks++; if (round_over !== 1'b1 || win !== 3'b001 || balance[31:0] !== 32'h0000_0F00) begin errors++;
      $display("FAIL round_end: got ro=%b win=%b bal0=%h want 1 001 00000f00", round_over, win, balance[31:0]); end
    idle();
    checks++; if (ready !== 1'b1 || round_over !== 1'b0 || win !== '0 || max_bid !== 16'h0100) begin errors++;
      $display("FAIL after_round: got ready=%b ro=%b win=%b max=%h want 1 0 000 0100", ready, round_over, win, max_bid); end
  endtask

  task automatic test_unlock();
    op(4'd1, 32'h0000_1234);
    checks++; if (err !== 3'b001) begin errors++; $display("FAIL bad_key: got err=%b want 001", err); end
    op(4'd3, 32'h1000_0500);
    checks++; if (err !== 3'b010 || balance[63:32] !== 32'd0) begin errors++;
      $display("FAIL still_locked: got err=%b bal1=%h want 010 0", err, balance[63:32]); end
    op(4'd1, 32'h0000_A5A5);
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL good_key: got err=%b want 000", err); end
    op(4'd3, 32'h1000_1000);
    checks++; if (err !== 3'b000 || balance[63:32] !== 32'h0000_1000) begin errors++;
      $display("FAIL unlocked_load: got err=%b bal1=%h want 000 00001000", err, balance[63:32]); end
  endtask

  task automatic test_tie_and_balance();
    op(4'd3, 32'h2000_1000);
    op(4'd3, 32'h3000_0001);
    checks++; if (err !== 3'b010) begin errors++; $display("FAIL bad_index: got err=%b want 010", err); end
    op(4'd4, 32'd3);
    op(4'd2, 32'h0000_A5A5);
    step('0, '0, '0, 4'd0, 32'd0, 1'b1);
    step(3'b110, '0, amts3(16'h0, 16'h0200, 16'h0200), 4'd0, 32'd0, 1'b0);
    checks++; if (ack !== 3'b010 || bidder_err !== 6'b10_00_00 || max_bid !== 16'h0200) begin errors++;
      $display("FAIL tie: got ack=%b berr=%b max=%h want 010 100000 0200", ack, bidder_err, max_bid); end
    step(3'b001, '0, amts3(16'h2000, 16'h0, 16'h0), 4'd0, 32'd0, 1'b0);
    checks++; if (bidder_err !== 6'b00_00_01 || ack !== '0 || max_bid !== 16'h0200) begin errors++;
      $display("FAIL no_funds: got berr=%b ack=%b max=%h want 000001 000 0200", bidder_err, ack, max_bid); end
    idle();
    checks++; if (round_over !== 1'b1 || win !== 3'b010 || balance[63:32] !== 32'h0000_0E00 || balance[95:64] !== 32'h0000_1000) begin errors++;
      $display("FAIL tie_end: got ro=%b win=%b bal1=%h bal2=%h want 1 010 00000e00 00001000", round_over, win, balance[63:32], balance[95:64]); end
    idle();
  endtask

  task automatic test_illegal_ops();
    op(4'd7, 32'd0);
    checks++; if (err !== 3'b011) begin errors++; $display("FAIL bad_opcode: got err=%b want 011", err); end
    idle();
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL err_pulse: got err=%b want 000", err); end
    op(4'd4, 32'd9);
    checks++; if (err !== 3'b010) begin errors++; $display("FAIL timer_locked: got err=%b want 010", err); end
    step(3'b001, '0, amts3(16'h0010, 16'h0, 16'h0), 4'd0, 32'd0, 1'b0);
    checks++; if (bidder_err !== 6'b00_00_11 || ack !== '0) begin errors++;
      $display("FAIL bid_idle: got berr=%b ack=%b want 000011 000", bidder_err, ack); end
    step('0, '0, '0, 4'd0, 32'd0, 1'b1);
    op(4'd4, 32'd1);
    checks++; if (err !== 3'b010 || ready !== 1'b0) begin errors++;
      $display("FAIL op_in_round: got err=%b ready=%b want 010 0", err, ready); end
    idle();
    idle();
    checks++; if (round_over !== 1'b1 || win !== '0) begin errors++;
      $display("FAIL empty_round: got ro=%b win=%b want 1 000", round_over, win); end
    idle();
  endtask

  task automatic test_zero_timer();
    op(4'd1, 32'h0000_A5A5);
    op(4'd4, 32'd0);
    op(4'd2, 32'h0000_0BAD);
    step('0, '0, '0, 4'd0, 32'd0, 1'b1);
    checks++; if (ready !== 1'b0 || round_over !== 1'b0) begin errors++;
      $display("FAIL zero_start: got ready=%b ro=%b want 0 0", ready, round_over); end
    idle();
    checks++; if (round_over !== 1'b1) begin errors++; $display("FAIL zero_timer: got ro=%b want 1", round_over); end
    idle();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL zero_back: got ready=%b want 1", ready); end
  endtask

`ifdef BID_RETRACT_EN
  task automatic test_retract();
    op(4'd1, 32'h0000_0BAD);
    op(4'd3, 32'h0000_1000);
    op(4'd4, 32'd4);
    op(4'd2, 32'h0000_A5A5);
    step('0, '0, '0, 4'd0, 32'd0, 1'b1);
    step(3'b001, '0, amts3(16'h0100, 16'h0, 16'h0), 4'd0, 32'd0, 1'b0);
    step(3'b001, 3'b011, amts3(16'h0300, 16'h0, 16'h0), 4'd0, 32'd0, 1'b0);
    checks++; if (ack !== 3'b001 || max_bid !== 16'h0000 || bidder_err !== 6'b00_10_00) begin errors++;
      $display("FAIL retract: got ack=%b max=%h berr=%b want 001 0000 001000", ack, max_bid, bidder_err); end
    idle();
    idle();
    checks++; if (round_over !== 1'b1 || win !== '0 || balance[31:0] !== 32'h0000_1000) begin errors++;
      $display("FAIL retract_end: got ro=%b win=%b bal0=%h want 1 000 00001000", round_over, win, balance[31:0]); end
    idle();
  endtask
`endif

  task automatic test_reset_mid_round();
    op(4'd1, m_key);
    op(4'd4, 32'd6);
    op(4'd2, 32'h0000_0005);
    step('0, '0, '0, 4'd0, 32'd0, 1'b1);
    step(3'b001, '0, amts3(16'h0080, 16'h0, 16'h0), 4'd0, 32'd0, 1'b0);
    checks++; if (ack !== 3'b001) begin errors++; $display("FAIL mid_bid: got ack=%b want 001", ack); end
    #2 reset = 1'b1;
    #1;
    checks++; if (ready !== 1'b1 || max_bid !== '0 || balance !== '0 || ack !== '0) begin errors++;
      $display("FAIL async_reset: got ready=%b max=%h bal=%h ack=%b want 1 0 0 0", ready, max_bid, balance, ack); end
    @(posedge clk); #1 reset = 1'b0;
    model_reset();
    for (int k = 0; k < 8; k++) begin
      idle();
      checks++; if (round_over !== 1'b0 || win !== '0 || ready !== 1'b1) begin errors++;
        $display("FAIL aborted_round: cycle %0d got ro=%b win=%b ready=%b want 0 000 1", k, round_over, win, ready); end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] b, r;
    logic [N*AW-1:0] amts;
    logic [3:0] o;
    logic [31:0] d;
    logic st;
    logic [3:0] ix;
    logic [27:0] v;
    logic [AW-1:0] same;
    int pick;
    for (int k = 0; k < 1500; k++) begin
      b = '0; r = N'($urandom); o = 4'd0; d = $urandom; st = 1'b0;
      for (int i = 0; i < N; i++) amts[i*AW +: AW] = AW'($urandom_range(0, 'h3000));
      pick = $urandom_range(0, 9);
      case (m_mode)
        M_UNL: begin
          if (pick <= 3) begin
            ix = 4'($urandom_range(0, 3)); v = 28'($urandom_range(0, 'h3000)); o = 4'd3; d = {ix, v};
          end else if (pick == 4) begin o = 4'd4; d = 32'($urandom_range(0, 8)); end
          else if (pick == 5) o = 4'd2;
          else if (pick == 6) o = 4'($urandom_range(5, 15));
          else if (pick == 7) o = 4'd1;
          else begin b = N'($urandom); st = 1'($urandom); end
        end
        M_LCK: begin
          if (pick <= 5) st = 1'b1;
          else if (pick == 6) o = 4'd1;
          else if (pick == 7) begin o = 4'd1; d = m_key; end
          else if (pick == 8) o = 4'($urandom_range(2, 15));
        end
        default: begin
          b = N'($urandom);
          if (pick == 0) begin
            same = AW'($urandom_range(0, 'h1800));
            amts = amts3(same, same, same);
          end
          if (pick == 1) o = 4'($urandom_range(0, 15));
          st = 1'($urandom);
        end
      endcase
      step(b, r, amts, o, d, st);
      checks++;
      if ({ack, bidder_err, win, round_over, err, ready} !==
          {e_ack, e_berr, e_win, e_ro, e_err, (m_mode == M_UNL || m_mode == M_LCK)}) begin
        errors++;
        $display("FAIL rand_ctl cyc %0d: got ack=%b berr=%b win=%b ro=%b err=%b rdy=%b want ack=%b berr=%b win=%b ro=%b err=%b",
                 k, ack, bidder_err, win, round_over, err, ready, e_ack, e_berr, e_win, e_ro, e_err);
      end
      checks++; if (max_bid !== AW'(m_max)) begin errors++;
        $display("FAIL rand_max cyc %0d: got %h want %h", k, max_bid, AW'(m_max)); end
      checks++; if (balance !== exp_bal()) begin errors++;
        $display("FAIL rand_bal cyc %0d: got %h want %h", k, balance, exp_bal()); end
    end
  endtask

  initial begin
    test_reset();
    test_setup();
    test_single_round();
    test_unlock();
    test_tie_and_balance();
    test_illegal_ops();
    test_zero_timer();
`ifdef BID_RETRACT_EN
    test_retract();
`endif
    test_reset_mid_round();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
